// File: rtl/aes_core_sched_pkg.sv
// Shared AES constants, operation codes and the held-result payload for the core scheduler.
package aes_core_sched_pkg;

    localparam int unsigned NK    = 4;
    localparam int unsigned NR    = 10;
    localparam int unsigned BLK_S = 32 * NK;
    localparam int unsigned RK_W  = $clog2(NR + 1);

    localparam logic OP_ENC = 1'b0;
    localparam logic OP_DEC = 1'b1;

    typedef struct packed {
        logic             op;
        logic             err;
        logic [BLK_S-1:0] data;
    } result_t;

endpackage

// File: rtl/aes_core_sched_watchdog.sv
// Completion watchdog: counts enabled cycles after a clear and flags the TIMEOUT-th one.
module aes_watchdog #(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // cnt holds the number of earlier enabled cycles, so the current cycle is number cnt+1
    assign expired_c = en && (cnt >= CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en && !expired_c) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/aes_core_sched.sv
// Single-block AES sequencer: accepts a command, starts the encrypt or decrypt core,
// steers the shared round-key RAM address and holds the result until it is taken.
module aes_core_sched
    import aes_core_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT = 32,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_op,
    input  logic [BLK_S-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [BLK_S-1:0] m_data,
    output logic             m_op,
    output logic             m_err,
    output logic             enc_en,
    output logic [BLK_S-1:0] enc_blk,
    input  logic [RK_W-1:0]  enc_round_no,
    input  logic             enc_done,
    input  logic [BLK_S-1:0] enc_res,
    output logic             dec_en,
    output logic [BLK_S-1:0] dec_blk,
    input  logic [RK_W-1:0]  dec_round_no,
    input  logic             dec_done,
    input  logic [BLK_S-1:0] dec_res,
    output logic [RK_W-1:0]  rk_addr,
    output logic             busy,
    output logic [CNT_W-1:0] enc_cnt,
    output logic [CNT_W-1:0] dec_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           state;
    logic             cur_op;
    logic [BLK_S-1:0] blk_r;
    logic             key_lost;
    result_t          res_r;

    logic             done_c;
    logic [BLK_S-1:0] core_res_c;
    logic             lost_c;
    logic             expired_c;

    aes_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clr       (state == START),
        .en        (state == RUN),
        .expired_c (expired_c)
    );

    // Only the active core is observed; the other core's done is ignored.
    assign done_c     = (cur_op == OP_DEC) ? dec_done : enc_done;
    assign core_res_c = (cur_op == OP_DEC) ? dec_res  : enc_res;
    assign lost_c     = key_lost || !key_valid;

    assign rk_addr = (cur_op == OP_DEC) ? dec_round_no : enc_round_no;
    assign enc_blk = blk_r;
    assign dec_blk = blk_r;
    assign m_data  = res_r.data;
    assign m_op    = res_r.op;
    assign m_err   = res_r.err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cur_op   <= OP_ENC;
            blk_r    <= '0;
            key_lost <= 1'b0;
            res_r    <= '0;
            s_ready  <= 1'b0;
            m_valid  <= 1'b0;
            enc_en   <= 1'b0;
            dec_en   <= 1'b0;
            busy     <= 1'b0;
            enc_cnt  <= '0;
            dec_cnt  <= '0;
        end else begin
            enc_en <= 1'b0;
            dec_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_valid && s_ready) begin
                        cur_op  <= s_op;
                        blk_r   <= s_data;
                        enc_en  <= (s_op == OP_ENC);
                        dec_en  <= (s_op == OP_DEC);
                        s_ready <= 1'b0;
                        busy    <= 1'b1;
                        state   <= START;
                    end else begin
                        s_ready <= key_valid;
                    end
                end
                START: begin
                    key_lost <= 1'b0;
                    state    <= RUN;
                end
                RUN: begin
                    if (!key_valid) begin
                        key_lost <= 1'b1;
                    end
                    // A done in the timeout cycle takes priority over the abort.
                    if (done_c) begin
                        res_r.op   <= cur_op;
                        res_r.err  <= lost_c;
                        res_r.data <= lost_c ? '0 : core_res_c;
                        m_valid    <= 1'b1;
                        state      <= HOLD;
                    end else if (expired_c) begin
                        res_r.op   <= cur_op;
                        res_r.err  <= 1'b1;
                        res_r.data <= '0;
                        m_valid    <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        s_ready <= key_valid;
                        busy    <= 1'b0;
                        state   <= IDLE;
                        if (cur_op == OP_DEC) begin
                            if (dec_cnt != '1) begin
                                dec_cnt <= dec_cnt + CNT_W'(1);
                            end
                        end else begin
                            if (enc_cnt != '1) begin
                                enc_cnt <= enc_cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_core_sched.sv
// Scoreboard bench for aes_core_sched: behavioural core/key model, randomized commands, decoupled monitor.
module tb_aes_core_sched;

    localparam int unsigned TIMEOUT = 20;
    localparam int unsigned CNT_W   = 3;
    localparam int          CMAX    = (1 << CNT_W) - 1;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic             clk;
    logic             reset;
    logic             key_valid;
    logic             s_valid;
    logic             s_ready;
    logic             s_op;
    logic [127:0]     s_data;
    logic             m_valid;
    logic             m_ready;
    logic [127:0]     m_data;
    logic             m_op;
    logic             m_err;
    logic             enc_en;
    logic [127:0]     enc_blk;
    logic [3:0]       enc_round_no;
    logic             enc_done;
    logic [127:0]     enc_res;
    logic             dec_en;
    logic [127:0]     dec_blk;
    logic [3:0]       dec_round_no;
    logic             dec_done;
    logic [127:0]     dec_res;
    logic [3:0]       rk_addr;
    logic             busy;
    logic [CNT_W-1:0] enc_cnt;
    logic [CNT_W-1:0] dec_cnt;

    aes_core_sched #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_valid    (key_valid),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_op         (s_op),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_op         (m_op),
        .m_err        (m_err),
        .enc_en       (enc_en),
        .enc_blk      (enc_blk),
        .enc_round_no (enc_round_no),
        .enc_done     (enc_done),
        .enc_res      (enc_res),
        .dec_en       (dec_en),
        .dec_blk      (dec_blk),
        .dec_round_no (dec_round_no),
        .dec_done     (dec_done),
        .dec_res      (dec_res),
        .rk_addr      (rk_addr),
        .busy         (busy),
        .enc_cnt      (enc_cnt),
        .dec_cnt      (dec_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    typedef struct {
        logic         op;
        logic         err;
        logic [127:0] data;
        int           lat;
    } exp_t;
    exp_t sbq[$];

    // Stand-in core transform; the FIPS-197 C.1 pair maps exactly.
    function automatic logic [127:0] core_fn(input logic op, input logic [127:0] b);
        if (!op && b == PT) return CT;
        if (op && b == CT) return PT;
        if (op) return b ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;
        return {b[95:0], b[127:96]} + 128'd1;
    endfunction

    int cfg_lat   = 11;
    bit cfg_silent = 1'b0;
    int cfg_dkey  = 0;
    int cfg_stray = 0;
    bit key_base  = 1'b1;
    int rdy_mode  = 0;

    // Behavioural cores + key RAM owner: done after cfg_lat cycles, optional key drop and stray done.
    initial begin
        int c_t, c_lat, c_dkey, c_stray;
        bit c_act, c_silent, c_op, rst_s;
        logic [127:0] c_blk;
        enc_done = 0; dec_done = 0; enc_res = '0; dec_res = '0;
        key_valid = 0; enc_round_no = '0; dec_round_no = '0;
        c_act = 0; c_t = 0; c_lat = 0; c_dkey = 0; c_stray = 0; c_silent = 0; c_op = 0;
        forever begin
            @(posedge clk);
            rst_s = reset;
            #1;
            enc_done = 0; dec_done = 0; key_valid = key_base;
            enc_res = {$urandom, $urandom, $urandom, $urandom};
            dec_res = {$urandom, $urandom, $urandom, $urandom};
            enc_round_no = 4'($urandom); dec_round_no = 4'($urandom);
            if (rst_s) begin
                c_act = 0;
            end else if (enc_en || dec_en) begin
                c_act = 1; c_t = 0; c_op = dec_en; c_blk = dec_en ? dec_blk : enc_blk;
                c_lat = cfg_lat; c_silent = cfg_silent; c_dkey = cfg_dkey; c_stray = cfg_stray;
            end else if (c_act) begin
                c_t++;
                if (c_t == c_dkey) key_valid = 0;
                if (c_t == c_stray) begin
                    if (c_op) enc_done = 1; else dec_done = 1;
                end
                if (!c_silent && c_t == c_lat) begin
                    c_act = 0;
                    if (c_op) begin dec_done = 1; dec_res = core_fn(1'b1, c_blk); end
                    else begin enc_done = 1; enc_res = core_fn(1'b0, c_blk); end
                end
                if (c_t > 200) c_act = 0;
            end else if ($urandom_range(0, 7) == 0) begin
                enc_done = 1'($urandom); dec_done = 1'($urandom);
            end
        end
    end

    initial begin
        m_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1;
                1:       m_ready = 1'($urandom);
                default: m_ready = 0;
            endcase
        end
    end

    bit rst_prev = 1, mv_prev = 0, kv_prev = 0, hs_prev = 0, act = 0, pend = 0;
    logic exp_op = 0;
    int acc_cyc = 0, start_cyc = 0, m_enc = 0, m_dec = 0;

    // Monitor: samples on the falling edge, pops the scoreboard on each handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_prev) begin
                chk("rst_m_valid", m_valid, 0); chk("rst_m_data", m_data, 0);
                chk("rst_m_err", m_err, 0);     chk("rst_m_op", m_op, 0);
                chk("rst_en", {enc_en, dec_en}, 0); chk("rst_busy", busy, 0);
                chk("rst_s_ready", s_ready, 0);
                chk("rst_enc_cnt", enc_cnt, 0); chk("rst_dec_cnt", dec_cnt, 0);
                chk("rst_rk_addr", rk_addr, enc_round_no);
                sbq.delete(); m_enc = 0; m_dec = 0; act = 0; pend = 0; exp_op = 0; hs_prev = 0;
            end else begin
                chk("rk_addr", rk_addr, exp_op ? dec_round_no : enc_round_no);
                chk("enc_cnt", enc_cnt, m_enc);
                chk("dec_cnt", dec_cnt, m_dec);
                chk("busy", busy, act);
                if (pend && cyc > acc_cyc + 1) begin
                    chk("en_missing", enc_en | dec_en, 1);
                    pend = 0;
                end
                if (enc_en || dec_en) begin
                    chk("en_one_hot", enc_en & dec_en, 0);
                    chk("en_timing", pend && (cyc == acc_cyc + 1), 1);
                    chk("en_sel", {enc_en, dec_en}, exp_op ? 2'b01 : 2'b10);
                    pend = 0;
                    start_cyc = cyc;
                end
                if (hs_prev && kv_prev) chk("s_ready_after_hs", s_ready, 1);
                hs_prev = 0;
                if (m_valid) begin
                    chk("s_ready_hold", s_ready, 0);
                    if (sbq.size() == 0) begin
                        chk("m_valid_unexpected", m_valid, 0);
                    end else begin
                        if (!mv_prev) chk("result_latency", cyc - start_cyc, sbq[0].lat);
                        chk("m_data", m_data, sbq[0].data);
                        chk("m_op", m_op, sbq[0].op);
                        chk("m_err", m_err, sbq[0].err);
                        if (m_ready) begin
                            if (sbq[0].op) begin if (m_dec < CMAX) m_dec++; end
                            else begin if (m_enc < CMAX) m_enc++; end
                            void'(sbq.pop_front());
                            act = 0;
                            hs_prev = 1;
                        end
                    end
                end
                if (s_valid && s_ready) begin
                    exp_op = s_op; acc_cyc = cyc; pend = 1; act = 1;
                end
            end
            mv_prev = m_valid; kv_prev = key_valid; rst_prev = reset;
        end
    end

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int lat, input bit sil, input int dk, input int st);
        cfg_lat = lat; cfg_silent = sil; cfg_dkey = dk; cfg_stray = st;
    endtask

    // Issue one command from posedge+1; the expected response is queued at acceptance.
    task automatic send(input logic op, input logic [127:0] d);
        exp_t e;
        int   eff, b;
        bit   ok;
        eff   = cfg_silent ? TIMEOUT : ((cfg_lat < TIMEOUT) ? cfg_lat : TIMEOUT);
        e.op  = op;
        e.err = cfg_silent || (cfg_lat > TIMEOUT) || (cfg_dkey >= 1 && cfg_dkey <= eff);
        e.data = e.err ? 128'd0 : core_fn(op, d);
        e.lat = (cfg_silent || cfg_lat > TIMEOUT) ? TIMEOUT + 1 : cfg_lat + 1;
        s_valid = 1; s_op = op; s_data = d;
        b = 0; ok = 0;
        forever begin
            @(negedge clk);
            if (s_ready) begin ok = 1; break; end
            b++;
            if (b > 100) begin chk("accept_timeout", s_ready, 1); break; end
        end
        if (ok) sbq.push_back(e);
        to_pos();
        s_valid = 0; s_op = 1'($urandom); s_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        forever begin
            @(negedge clk);
            if (!busy && !m_valid && sbq.size() == 0) break;
            b++;
            if (b > 400) begin
                chk("idle_timeout", {busy, m_valid, 30'(sbq.size())}, 0);
                break;
            end
        end
        to_pos();
    endtask

    initial begin
        reset = 1; s_valid = 0; s_op = 0; s_data = '0;
        repeat (3) to_pos();
        reset = 0;
        repeat (2) to_pos();

        // FIPS-197 C.1 encrypt, then decrypt of its ciphertext
        set_cfg(11, 0, 0, 0); send(1'b0, PT); wait_idle();
        set_cfg(11, 0, 0, 0); send(1'b1, CT); wait_idle();

        // backpressure: result held 20 cycles
        @(negedge clk); rdy_mode = 2; to_pos();
        set_cfg(5, 0, 0, 0); send(1'b0, PT);
        begin
            int b;
            b = 0;
            forever begin
                @(negedge clk);
                if (m_valid) break;
                b++;
                if (b > 100) begin chk("mvalid_timeout", m_valid, 1); break; end
            end
        end
        repeat (20) @(negedge clk);
        rdy_mode = 0; to_pos();
        wait_idle();

        // timeouts, done exactly at the limit, stray done from the idle core
        set_cfg(0, 1, 0, 0);               send(1'b0, PT);  wait_idle();
        set_cfg(TIMEOUT, 0, 0, 0);         send(1'b0, 128'h1234); wait_idle();
        set_cfg(TIMEOUT + 1, 0, 0, 0);     send(1'b1, 128'h5678); wait_idle();
        set_cfg(0, 1, 0, 5);               send(1'b1, CT);  wait_idle();
        set_cfg(12, 0, 0, 3);              send(1'b1, CT);  wait_idle();

        // key_valid low in IDLE blocks acceptance
        @(negedge clk); key_base = 0; to_pos(); to_pos();
        s_valid = 1; s_op = 0; s_data = PT;
        repeat (10) begin
            @(negedge clk);
            chk("s_ready_nokey", s_ready, 0);
        end
        to_pos(); s_valid = 0;
        @(negedge clk); key_base = 1; to_pos(); to_pos();

        // key dropped for one RUN cycle
        set_cfg(10, 0, 4, 0); send(1'b0, PT); wait_idle();

        // reset while RUN, then a normal command
        set_cfg(15, 0, 0, 0); send(1'b1, CT);
        repeat (5) to_pos();
        reset = 1; to_pos(); reset = 0;
        wait_idle();
        set_cfg(7, 0, 0, 0); send(1'b0, PT); wait_idle();

        // randomized commands; enough of each direction to saturate the counters
        for (int i = 0; i < 30; i++) begin
            logic         op;
            logic [127:0] d;
            int           lat, dk, st;
            bit           sil;
            op  = (i < 16) ? 1'(i % 2) : 1'($urandom);
            d   = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 5) == 0) d = op ? CT : PT;
            lat = $urandom_range(1, TIMEOUT + 2);
            sil = ($urandom_range(0, 7) == 0);
            dk  = 0;
            st  = 0;
            if ($urandom_range(0, 4) == 0 && lat >= 2) dk = $urandom_range(1, lat - 1);
            if ($urandom_range(0, 3) == 0 && lat >= 2) st = $urandom_range(1, lat - 1);
            @(negedge clk); rdy_mode = $urandom_range(0, 1); to_pos();
            set_cfg(lat, sil, dk, st);
            send(op, d);
            wait_idle();
        end

        @(negedge clk); rdy_mode = 0;
        repeat (3) to_pos();
        chk("scoreboard_drained", 32'(sbq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/aes_core_sched.md
# aes_core_sched

Sequences single-block AES operations between the upstream command stream and the encrypt and decrypt cores, which share one round-key RAM read port. It accepts one command at a time and starts the selected core with a one-cycle enable. It steers the key-RAM read address from the active core and captures that core's result. It then holds the result on a valid/ready output until it is consumed. It also adds a completion watchdog, key-loss detection and saturating per-direction operation counters.

## Interface
Parameters:
- TIMEOUT, 32: maximum number of cycles from the core enable to the core done pulse before the operation is aborted.
- CNT_W, 16: width of each operation counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- key_valid  in  1  expanded key schedule is present and stable in the key RAM.
- s_valid  in  1  command valid.
- s_ready  out  1  command accepted on s_valid && s_ready.
- s_op  in  1  operation select: 0 = encrypt, 1 = decrypt.
- s_data  in  128  input block.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumed on m_valid && m_ready.
- m_data  out  128  result block.
- m_op  out  1  echo of s_op for this result.
- m_err  out  1  result aborted (timeout or key lost); m_data is zero when set.
- enc_en  out  1  encrypt core start pulse.
- enc_blk  out  128  encrypt core input block.
- enc_round_no  in  4  encrypt core round-key index.
- enc_done  in  1  encrypt core done pulse.
- enc_res  in  128  encrypt core result.
- dec_en, dec_blk, dec_round_no, dec_done, dec_res: the same set for the decrypt core.
- rk_addr  out  4  key-RAM read address; the RAM has a 1-cycle read latency and its data goes directly to both cores.
- busy  out  1  state is not IDLE.
- enc_cnt, dec_cnt  out  CNT_W  number of completed operations per direction, including error completions; saturating.

## Operation
- The state machine has four states: IDLE, START, RUN and HOLD.
- IDLE:
  - s_ready = key_valid.
  - On accept, the block registers s_op into cur_op and s_data into blk_r, then moves to START.
- START:
  - Asserts exactly one of enc_en or dec_en for one cycle, selected by cur_op.
  - Clears the watchdog counter and moves to RUN.
- RUN:
  - The block watches only the done input of the active core.
  - On done, it captures that core's result into m_data, sets m_op = cur_op and m_err = 0, then moves to HOLD.
  - The watchdog counts cycles in RUN. When the count reaches TIMEOUT, it sets m_err = 1 and m_data = 0, then moves to HOLD.
  - If key_valid is low on any RUN cycle, a sticky key_lost flag is set. A done that arrives with key_lost set is reported as m_err = 1 with m_data = 0.
- HOLD:
  - m_valid = 1, and m_data, m_op and m_err stay stable until the handshake.
  - On m_valid && m_ready, the counter for cur_op increments (saturating at all-ones) and the state returns to IDLE.
  - s_ready = 0 in HOLD; there is no overlap of operations.
- rk_addr = enc_round_no when cur_op = 0, otherwise dec_round_no, in every state. cur_op holds its value in IDLE.
- enc_blk and dec_blk are both driven from blk_r.
- Ignored inputs: a done from the inactive core, and any done outside RUN. A done arriving in the same cycle as the timeout wins, and its result is delivered normally.

## Timing
- Reset values:
  - state IDLE, s_ready = 0 until key_valid is seen.
  - m_valid, m_err, m_op = 0; m_data = 0.
  - enc_en, dec_en = 0; enc_cnt, dec_cnt = 0.
  - cur_op = 0, key_lost = 0, rk_addr follows enc_round_no.
- The core enable is asserted in the cycle after the accept cycle.
- m_valid rises in the cycle after the done pulse, or in the cycle after the timeout.
- The earliest next accept is the cycle after the m_valid && m_ready handshake, because s_ready is registered with the state.
- Total overhead outside the core is 3 cycles: accept, start, and capture.
- Reset asserted mid-operation returns the block to IDLE in the next cycle with no result emitted. The cores share the same reset.
- If m_ready is held high in HOLD, the handshake completes in the first HOLD cycle.

## Structure
- The shared package aes.vh provides BLK_S = 128, Nk = 4, Nr = 10, and two new constants: OP_ENC = 1'b0 and OP_DEC = 1'b1.
- State encodings are local to this module.
- The watchdog is the one natural sub-module: aes_watchdog, a loadable counter with clear, enable and expired output, parameterised by TIMEOUT.

## Test plan
- Encrypt, FIPS-197 C.1: key 000102…0f, block 00112233…eeff.
  - Required: m_data = 69c4e0d86a7b0430d8cdb78070b4c55a, m_op = 0, m_err = 0.
  - Required: enc_en fires exactly once, one cycle after accept, and enc_cnt = 1.
- Decrypt of the same ciphertext:
  - Required: m_data = 00112233…eeff, m_op = 1, and rk_addr tracks dec_round_no throughout.
  - Required: dec_cnt = 1 and enc_cnt is unchanged.
- Backpressure: hold m_ready = 0 for 20 cycles.
  - Required: m_data is stable and s_ready = 0 throughout.
  - Required: after m_ready goes high, the handshake completes and s_ready returns high in the next cycle.
- Timeout: the core model never pulses done.
  - Required: m_err = 1 and m_data = 0 exactly TIMEOUT + 1 cycles after the start pulse.
  - Required: a stray enc_done injected while the block is in the decrypt RUN state is ignored.
- key_valid handling:
  - key_valid = 0 in IDLE: s_ready = 0 and no enable pulse is issued.
  - key_valid dropped for one RUN cycle: the result is delivered with m_err = 1.
- Reset in RUN: no m_valid is produced, the block returns to IDLE, and the next command completes correctly.
